// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port valid/ready arbiter and sequencer with read-modify-write byte stores for a word memory
module dmem_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_we,
  input  logic [3:0]  p0_be,
  output logic        p0_resp_valid,
  output logic [31:0] p0_resp_rdata,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_we,
  input  logic [3:0]  p1_be,
  output logic        p1_resp_valid,
  output logic [31:0] p1_resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
  state_t state, state_n;
  logic last_grant, win, hs, c_port, c_we, full, none, partial, done;
  logic [31:0] c_addr, c_wdata, old, mask;
  logic [3:0] c_be;
  assign win = p1_valid && (!p0_valid || (ARB_MODE == 0 && !last_grant));
  assign p0_ready = !rst && state == IDLE && p0_valid && !win;
  assign p1_ready = !rst && state == IDLE && win;
  assign hs = p0_ready || p1_ready;
  assign full = &c_be;
  assign none = ~|c_be;
  assign partial = c_we && !full && !none;
  assign done = (state == ACCESS && !partial) || state == MERGE;
  assign mask = {{8{c_be[3]}}, {8{c_be[2]}}, {8{c_be[1]}}, {8{c_be[0]}}};
  assign mem_re = !rst && state == ACCESS && (!c_we || partial);
  assign mem_we = !rst && (state == MERGE || (state == ACCESS && c_we && full));
  assign mem_addr = (state == ACCESS || state == MERGE) ? c_addr : '0;
  assign mem_wdata = state == MERGE ? (c_wdata & mask) | (old & ~mask) : c_wdata;
  assign p0_resp_valid = !rst && state == RESP && !c_port;
  assign p1_resp_valid = !rst && state == RESP && c_port;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state == IDLE ? (hs ? ACCESS : IDLE) :
              state == ACCESS ? (partial ? MERGE : RESP) :
              state == MERGE ? RESP : IDLE;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      p0_resp_rdata <= '0;
      p1_resp_rdata <= '0;
    end else begin
      if (hs) begin
        last_grant <= win;
        c_port <= win;
        c_addr <= win ? p1_addr : p0_addr;
        c_wdata <= win ? p1_wdata : p0_wdata;
        c_we <= win ? p1_we : p0_we;
        c_be <= win ? p1_be : p0_be;
      end
      if (state == ACCESS && partial) old <= mem_rdata;
      if (done && !c_port) p0_resp_rdata <= c_we ? '0 : mem_rdata;
      if (done && c_port) p1_resp_rdata <= c_we ? '0 : mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector bench for dmem_arbiter with a word memory model
module tb_dmem_arbiter;
  typedef struct {
    logic port;
    logic we;
    logic [3:0] be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [31:0] word;
    int lat;
    int wes;
    int res;
  } vec_t;
  logic clk, rst;
  logic p0_valid, p0_ready, p0_we, p0_rv, p1_valid, p1_ready, p1_we, p1_rv;
  logic [31:0] p0_addr, p0_wdata, p0_rd, p1_addr, p1_wdata, p1_rd;
  logic [3:0] p0_be, p1_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic m_we, m_re, busy;
  logic q0_ready, q1_ready, q0_rv, q1_rv, q_we, q_re, q_busy;
  logic [31:0] q0_rd, q1_rd, q_addr, q_wdata, q_rdata;
  logic [31:0] mem [0:1023];
  logic pl_we;
  logic [9:0] pl_idx;
  logic [31:0] pl_data;
  int checks, errors, we_cnt, re_cnt, r0_cnt, r1_cnt;
  vec_t v [8];
  dmem_arbiter #(.ARB_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_we(p0_we), .p0_be(p0_be), .p0_resp_valid(p0_rv), .p0_resp_rdata(p0_rd),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_we(p1_we), .p1_be(p1_be), .p1_resp_valid(p1_rv), .p1_resp_rdata(p1_rd),
    .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_we(m_we), .mem_re(m_re),
    .mem_rdata(m_rdata), .busy(busy)
  );
  dmem_arbiter #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(q0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_we(p0_we), .p0_be(p0_be), .p0_resp_valid(q0_rv), .p0_resp_rdata(q0_rd),
    .p1_valid(p1_valid), .p1_ready(q1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_we(p1_we), .p1_be(p1_be), .p1_resp_valid(q1_rv), .p1_resp_rdata(q1_rd),
    .mem_addr(q_addr), .mem_wdata(q_wdata), .mem_we(q_we), .mem_re(q_re),
    .mem_rdata(q_rdata), .busy(q_busy)
  );
  assign m_rdata = mem[m_addr[11:2]];
  assign q_rdata = mem[q_addr[11:2]];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    else if (m_we) mem[m_addr[11:2]] <= m_wdata;
  end
  always @(posedge clk) begin
    if (m_we) we_cnt <= we_cnt + 1;
    if (m_re) re_cnt <= re_cnt + 1;
    if (p0_rv) r0_cnt <= r0_cnt + 1;
    if (p1_rv) r1_cnt <= r1_cnt + 1;
    if (m_we && m_re) begin
      checks <= checks + 1;
      errors <= errors + 1;
      $display("FAIL strobes mem_we and mem_re both high, required exclusive");
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask
  task automatic poke(input int i, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_idx = i[9:0];
    pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask
  initial begin
    int lat, s_we, s_re, s_r0, s_r1;
    logic [31:0] rd;
    clk = 0; rst = 1; pl_we = 0; pl_idx = 0; pl_data = 0;
    checks = 0; errors = 0; we_cnt = 0; re_cnt = 0; r0_cnt = 0; r1_cnt = 0;
    p0_valid = 0; p0_addr = 0; p0_wdata = 0; p0_we = 0; p0_be = 0;
    p1_valid = 0; p1_addr = 0; p1_wdata = 0; p1_we = 0; p1_be = 0;
    v[0] = '{1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0, 1};
    v[1] = '{1'b0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 32'h11223344, 2, 1, 0};
    v[2] = '{1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h11223344, 32'h11223344, 2, 0, 1};
    v[3] = '{1'b1, 1'b1, 4'h4, 32'h30, 32'h00EE0000, 32'h0, 32'hAAEECCDD, 3, 1, 1};
    v[4] = '{1'b1, 1'b1, 4'h0, 32'h40, 32'hFFFFFFFF, 32'h0, 32'h12345678, 2, 0, 0};
    v[5] = '{1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 32'hAAEECCDD, 32'hAAEECCDD, 2, 0, 1};
    v[6] = '{1'b0, 1'b1, 4'h3, 32'h43, 32'hA5A5A5A5, 32'h0, 32'h1234A5A5, 3, 1, 1};
    v[7] = '{1'b0, 1'b1, 4'h9, 32'h1050, 32'h11223344, 32'h0, 32'h11000044, 3, 1, 1};
    @(negedge clk);
    p0_valid = 1; p1_valid = 1;
    #1;
    chk("rst_p0_ready", {31'b0, p0_ready}, 0);
    chk("rst_p1_ready", {31'b0, p1_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_mem_strobes", {30'b0, m_we, m_re}, 0);
    chk("rst_p0_rdata", p0_rd, 0);
    chk("rst_p1_rdata", p1_rd, 0);
    p0_valid = 0; p1_valid = 0;
    @(negedge clk);
    rst = 0;
    poke(4, 32'hDEADBEEF);
    poke(8, 32'h0);
    poke(12, 32'hAABBCCDD);
    poke(16, 32'h12345678);
    poke(20, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s_we = we_cnt; s_re = re_cnt; s_r0 = r0_cnt; s_r1 = r1_cnt;
      if (v[k].port) begin
        p1_valid = 1; p1_we = v[k].we; p1_be = v[k].be; p1_addr = v[k].addr; p1_wdata = v[k].wdata;
      end else begin
        p0_valid = 1; p0_we = v[k].we; p0_be = v[k].be; p0_addr = v[k].addr; p0_wdata = v[k].wdata;
      end
      #1;
      chk($sformatf("v%0d_ready", k), {31'b0, v[k].port ? p1_ready : p0_ready}, 1);
      @(posedge clk);
      #1;
      p0_valid = 0; p1_valid = 0;
      p0_addr = '1; p1_addr = '1; p0_wdata = 32'h5A5A5A5A; p1_wdata = 32'h5A5A5A5A;
      p0_be = ~p0_be; p1_be = ~p1_be; p0_we = ~p0_we; p1_we = ~p1_we;
      lat = -1;
      rd = 'x;
      for (int c = 1; c <= 8 && lat < 0; c++) begin
        @(negedge clk);
        if (v[k].port ? p1_rv : p0_rv) begin
          lat = c;
          rd = v[k].port ? p1_rd : p0_rd;
        end
      end
      @(negedge clk);
      chk($sformatf("v%0d_latency", k), lat, v[k].lat);
      chk($sformatf("v%0d_rdata", k), rd, v[k].rd);
      chk($sformatf("v%0d_word", k), mem[v[k].addr[11:2]], v[k].word);
      chk($sformatf("v%0d_we_cycles", k), we_cnt - s_we, v[k].wes);
      chk($sformatf("v%0d_re_cycles", k), re_cnt - s_re, v[k].res);
      chk($sformatf("v%0d_p0_resps", k), r0_cnt - s_r0, v[k].port ? 0 : 1);
      chk($sformatf("v%0d_p1_resps", k), r1_cnt - s_r1, v[k].port ? 1 : 0);
    end
    chk("p1_rdata_held", p1_rd, 32'hAAEECCDD);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    p0_valid = 1; p1_valid = 1; p0_we = 0; p1_we = 0; p0_addr = 32'h10; p1_addr = 32'h20;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("rr_grant_%0d", i), {30'b0, p1_ready, p0_ready}, i % 3 != 0 ? 32'd0 : ((i / 3) % 2 != 0 ? 32'd2 : 32'd1));
      chk($sformatf("fp_grant_%0d", i), {30'b0, q1_ready, q0_ready}, i % 3 != 0 ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    p0_valid = 0; p1_valid = 0;
    repeat (3) @(negedge clk);
    poke(24, 32'hCAFEBABE);
    @(negedge clk);
    s_we = we_cnt; s_r0 = r0_cnt; s_r1 = r1_cnt;
    p0_valid = 1; p0_we = 1; p0_be = 4'h1; p0_addr = 32'h60; p0_wdata = 32'h000000FF;
    @(posedge clk);
    #1;
    p0_valid = 0;
    @(negedge clk);
    chk("mr_access_re", {31'b0, m_re}, 1);
    @(negedge clk);
    chk("mr_merge_busy", {31'b0, busy}, 1);
    rst = 1;
    #1;
    chk("mr_we_forced", {31'b0, m_we}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("mr_idle", {31'b0, busy}, 0);
    chk("mr_word", mem[24], 32'hCAFEBABE);
    chk("mr_we_cycles", we_cnt - s_we, 0);
    chk("mr_resps", (r0_cnt - s_r0) + (r1_cnt - s_r1), 0);
    p0_valid = 1; p1_valid = 1; p0_we = 0; p1_we = 0;
    #1;
    chk("mr_tie_p0", {31'b0, p0_ready}, 1);
    chk("mr_tie_p1", {31'b0, p1_ready}, 0);
    p0_valid = 0; p1_valid = 0;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
